// File: rtl/sprite_rom_arbiter.sv
// Sprite-sheet ROM arbiter: display port 0 has strict priority, ports 1..N-1 share
// leftover cycles round-robin with optional bounded lock bursts; read data is tagged back.
module sprite_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 5,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data
);

    localparam int                IDX_W   = $clog2(NUM_REQ);
    localparam logic [7:0]        MAX_CNT = 8'(MAX_BURST);
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]  FIRST   = IDX_W'(1);

    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic               burst_reg, burst_next;
    logic [7:0]         cnt_reg, cnt_next;
    logic [NUM_REQ-1:0] tag_reg;

    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               cont_hit;
    int                 cand;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
            assign gnt[gi]      = !rst && sel_valid && (sel_idx == IDX_W'(gi));
        end
    endgenerate

    // Search runs from the far end back toward rr_ptr so the nearest requester overwrites.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        cont_hit  = burst_reg && req[owner_reg] && lock[owner_reg] && (cnt_reg < MAX_CNT);
        if (req[0]) begin
            sel_valid = 1'b1;
        end else if (cont_hit) begin
            sel_valid = 1'b1;
            sel_idx   = owner_reg;
        end else begin
            for (int off = NUM_REQ - 2; off >= 0; off--) begin
                cand = int'(rr_ptr_reg) + off;
                if (cand > NUM_REQ - 1) begin
                    cand = cand - (NUM_REQ - 1);
                end
                cand_idx = IDX_W'(cand);
                if (req[cand_idx]) begin
                    sel_valid = 1'b1;
                    sel_idx   = cand_idx;
                end
            end
        end
    end

    assign rom_addr = (!rst && sel_valid) ? addr_arr[sel_idx] : '0;

    // A port-0 grant falls through untouched, which pauses any burst in progress.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        burst_next  = burst_reg;
        cnt_next    = cnt_reg;
        if (sel_valid && sel_idx != '0) begin
            rr_ptr_next = (sel_idx == LAST) ? FIRST : sel_idx + FIRST;
            if (cont_hit) begin
                if (cnt_reg + 8'd1 >= MAX_CNT) begin
                    burst_next = 1'b0;
                    owner_next = '0;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end else if (lock[sel_idx] && MAX_CNT > 8'd1) begin
                burst_next = 1'b1;
                owner_next = sel_idx;
                cnt_next   = 8'd1;
            end else begin
                burst_next = 1'b0;
                owner_next = '0;
                cnt_next   = 8'd0;
            end
        end else if (!sel_valid) begin
            burst_next = 1'b0;
            owner_next = '0;
            cnt_next   = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= FIRST;
            owner_reg  <= '0;
            burst_reg  <= 1'b0;
            cnt_reg    <= 8'd0;
            tag_reg    <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
            burst_reg  <= burst_next;
            cnt_reg    <= cnt_next;
            tag_reg    <= gnt;
        end
    end

    assign rd_valid = tag_reg;
    assign rd_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios plus randomized traffic checked
// against a grant-rule reference model and a behavioural ROM.
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int DW = 5;
    localparam int MB = 8;
    localparam int BOUND = (N - 2) * MB + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    lock = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data = '0;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;

    logic [DW-1:0]   rom_mem [1 << AW];
    logic [AW-1:0]   addr_v [N];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // reference model state: port 0 never owns a burst, so owner 0 means none
    int m_ptr   = 1;
    int m_owner = 0;
    int m_cnt   = 0;

    sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr), .gnt(gnt),
        .rom_addr(rom_addr), .rom_data(rom_data), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input logic [N-1:0] l);
        if (r[0]) return 0;
        if (m_owner > 0 && r[m_owner] && l[m_owner] && m_cnt < MB) return m_owner;
        for (int s = 0; s < N - 1; s++) begin
            int p;
            p = 1 + (m_ptr - 1 + s) % (N - 1);
            if (r[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [N-1:0] r, input logic [N-1:0] l, input int g);
        if (g > 0) begin
            if (m_owner == g && r[g] && l[g] && m_cnt < MB) begin
                m_cnt++;
                if (m_cnt >= MB) begin m_owner = 0; m_cnt = 0; end
            end else if (l[g] && MB > 1) begin
                m_owner = g; m_cnt = 1;
            end else begin
                m_owner = 0; m_cnt = 0;
            end
            m_ptr = (g == N - 1) ? 1 : g + 1;
        end else if (g < 0) begin
            m_owner = 0; m_cnt = 0;
        end
    endtask

    task automatic model_reset();
        m_ptr = 1; m_owner = 0; m_cnt = 0;
    endtask

    // Called at posedge+1; leaves at the next posedge+1 after checking the return path.
    task automatic run_cycle(input logic [N-1:0] r, input logic [N-1:0] l,
                             output int g, output logic [N-1:0] obs);
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        req  = r;
        lock = l;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = addr_v[i];
        #1;
        g   = model_pick(r, l);
        eg  = (g >= 0) ? (N'(1) << g) : '0;
        ea  = (g >= 0) ? addr_v[g] : '0;
        obs = gnt;
        check_eq("gnt", gnt, eg);
        check_eq("rom_addr", rom_addr, ea);
        $display("cyc %0d req=%b lock=%b gnt=%b rom_addr=0x%h", cyc, r, l, gnt, rom_addr);
        @(posedge clk);
        model_update(r, l, g);
        #1;
        check_eq("rd_valid", rd_valid, eg);
        if (g >= 0) check_eq("rd_data", rd_data, rom_mem[ea]);
        cyc++;
    endtask

    task automatic reset_dut();
        rst  = 1'b1;
        req  = '1;
        lock = '1;
        @(posedge clk);
        #1;
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_rom_addr", rom_addr, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        req  = '0;
        lock = '0;
        rst  = 1'b0;
        model_reset();
    endtask

    initial begin
        int           g;
        logic [N-1:0] obs;
        logic [N-1:0] pend;
        logic [N-1:0] l;
        logic         r0;
        int           waitc [N];
        int           exp_rr [6]    = '{1, 2, 3, 1, 2, 3};
        int           exp_burst [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 2};

        for (int a = 0; a < (1 << AW); a++) rom_mem[a] = DW'($urandom);
        for (int i = 0; i < N; i++) addr_v[i] = AW'($urandom);
        rom_mem[14'h0123] = 5'h15;

        reset_dut();

        // single port-2 read
        addr_v[2] = 14'h0123;
        run_cycle(4'b0100, 4'b0000, g, obs);
        check_eq("p2_gnt", obs, 4'b0100);
        check_eq("p2_data", rd_data, 5'h15);

        // round-robin order from reset pointer
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            run_cycle(4'b1110, 4'b0000, g, obs);
            check_eq("rr_order", obs, N'(1) << exp_rr[k]);
        end

        // port 0 dominates; pointer must not advance
        for (int k = 0; k < 10; k++) begin
            run_cycle(4'b1111, 4'b0000, g, obs);
            check_eq("prio0", obs, 4'b0001);
        end
        run_cycle(4'b1110, 4'b0000, g, obs);
        check_eq("rr_after_prio", obs, 4'b0010);

        // locked burst on port 1 with a port-0 interruption
        reset_dut();
        for (int k = 0; k < 10; k++) begin
            run_cycle((k == 4) ? 4'b0111 : 4'b0110, 4'b0010, g, obs);
            check_eq("burst_seq", obs, N'(1) << exp_burst[k]);
        end

        // asynchronous reset in the middle of a cycle with a port-3 grant outstanding
        reset_dut();
        run_cycle(4'b1000, 4'b0000, g, obs);
        req = 4'b1000;
        #1;
        check_eq("pre_rst_gnt", gnt, 4'b1000);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_gnt", gnt, 0);
        check_eq("async_rom_addr", rom_addr, 0);
        check_eq("async_rd_valid", rd_valid, 0);
        @(posedge clk);
        #1;
        check_eq("post_rst_rd_valid", rd_valid, 0);
        req = '0;
        rst = 1'b0;
        model_reset();
        run_cycle(4'b0010, 4'b0000, g, obs);

        // randomized traffic: requesters hold until granted
        pend = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, (i == 0) ? 7 : 2) == 0) begin
                    pend[i]   = 1'b1;
                    addr_v[i] = AW'($urandom);
                    waitc[i]  = 0;
                end
            end
            l  = N'($urandom) | N'($urandom);
            r0 = pend[0];
            run_cycle(pend, l, g, obs);
            if (!r0) begin
                for (int i = 1; i < N; i++) if (pend[i]) waitc[i]++;
            end
            if (g > 0) check_eq("fair_wait", (waitc[g] <= BOUND), 1);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
